pipe_skid_stage: RTL

- Parametrised, multi-lane pipeline stage register for the dual-issue pipeline (e.g. between the mem and commit stages).
- Replaces the plain stall/flush register with a valid/ready handshake and a one-entry skid buffer, so upstream back-pressure is fully registered.
- Adds per-lane kill, so a precise exception in lane k can squash younger lanes without a full flush.

---
 rtl/pipe_skid_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - multi-lane valid/ready pipeline stage with one-entry skid buffer and per-lane kill
module pipe_skid_stage #(
  parameter int LANES = 2,
  parameter int W     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [LANES-1:0]     in_valid,
  input  logic [LANES*W-1:0]   in_data,
  output logic                 in_ready,
  output logic [LANES-1:0]     out_valid,
  output logic [LANES*W-1:0]   out_data,
  input  logic                 out_ready,
  input  logic [LANES-1:0]     kill_mask,
  output logic [1:0]           occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [LANES-1:0]     h_valid_q, h_valid_d;
  logic [LANES*W-1:0]   h_data_q, h_data_d;
  logic [LANES-1:0]     s_valid_q, s_valid_d;
  logic [LANES*W-1:0]   s_data_q, s_data_d;

  logic                 in_fire;
  logic                 out_fire;
  logic                 head_gone;
  logic [LANES*W-1:0]   keep_bits;
  logic [LANES-1:0]     h_keep_valid;
  logic [LANES*W-1:0]   h_keep_data;

  // in_ready depends only on registered state, so back-pressure never chains combinationally
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = h_valid_q & ~kill_mask;
  assign out_data  = h_data_q;
  assign in_fire   = in_ready & (|in_valid);
  assign out_fire  = (|out_valid) & out_ready;
  // A head whose valid lanes are all killed is retired exactly like a fired one
  assign head_gone = (state_q != ST_EMPTY) & (out_fire | ~(|out_valid));

  always_comb begin
    keep_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      keep_bits[i*W +: W] = {W{~kill_mask[i]}};
    end
  end

  assign h_keep_valid = h_valid_q & ~kill_mask;
  assign h_keep_data  = h_data_q & keep_bits;

  always_comb begin
    state_d   = state_q;
    h_valid_d = h_valid_q;
    h_data_d  = h_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d   = ST_ONE;
          h_valid_d = in_valid;
          h_data_d  = in_data;
        end
      end
      ST_ONE: begin
        if (head_gone) begin
          if (in_fire) begin
            h_valid_d = in_valid;
            h_data_d  = in_data;
          end else begin
            state_d   = ST_EMPTY;
            h_valid_d = '0;
            h_data_d  = '0;
          end
        end else begin
          h_valid_d = h_keep_valid;
          h_data_d  = h_keep_data;
          if (in_fire) begin
            state_d   = ST_TWO;
            s_valid_d = in_valid;
            s_data_d  = in_data;
          end
        end
      end
      ST_TWO: begin
        if (head_gone) begin
          state_d   = ST_ONE;
          h_valid_d = s_valid_q;
          h_data_d  = s_data_q;
          s_valid_d = '0;
          s_data_d  = '0;
        end else begin
          h_valid_d = h_keep_valid;
          h_data_d  = h_keep_data;
        end
      end
      default: begin
        state_d   = ST_EMPTY;
        h_valid_d = '0;
        h_data_d  = '0;
        s_valid_d = '0;
        s_data_d  = '0;
      end
    endcase

    if (flush) begin
      state_d   = ST_EMPTY;
      h_valid_d = '0;
      h_data_d  = '0;
      s_valid_d = '0;
      s_data_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      h_valid_q <= '0;
      h_data_q  <= '0;
      s_valid_q <= '0;
      s_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      h_valid_q <= h_valid_d;
      h_data_q  <= h_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_ONE:  occupancy = 2'd1;
      ST_TWO:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule
